// File: rtl/vanilla_load_scoreboard.sv
// vanilla_load_scoreboard: counts the remote loads still outstanding for each
// destination register, so a register can have several loads in flight and
// several responses can retire in the same cycle.
// Optional feature macro: VANILLA_LOAD_SB_CLEAR_BYPASS_EN. When defined,
// same-cycle clears are folded into dep_o so a retiring response frees its
// dependent instruction without an extra stall cycle.
module vanilla_load_scoreboard #(
  parameter int els_p           = 32,
  parameter int id_width_p      = $clog2(els_p),
  parameter int count_width_p   = 2,
  parameter int num_clear_p     = 2,
  parameter int num_check_p     = 3,
  parameter int hardwire_zero_p = 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  score_v_i,
  input  logic [id_width_p-1:0]                 score_id_i,
  output logic                                  score_ready_o,
  input  logic [num_clear_p-1:0]                clear_v_i,
  input  logic [num_clear_p-1:0][id_width_p-1:0] clear_id_i,
  input  logic [num_check_p-1:0][id_width_p-1:0] check_id_i,
  output logic [num_check_p-1:0]                dep_o,
  output logic [els_p-1:0]                      pending_o,
  output logic                                  idle_o,
  output logic                                  err_o
);

  localparam int dw = $clog2(num_clear_p + 1);
  // One spare sign bit above the largest possible cnt + 1, so that
  // cnt + inc - dec never wraps and its MSB flags an underflow.
  localparam int aw = count_width_p + dw + 1;
  localparam logic [count_width_p-1:0] cnt_max = '1;

  logic [count_width_p-1:0] cnt_r [els_p];
  logic [count_width_p-1:0] cnt_n [els_p];
  logic [dw-1:0]            dec   [els_p];
  logic [aw-1:0]            sum   [els_p];
  logic [els_p-1:0]         inc;
  logic [els_p-1:0]         uflow;
  logic [els_p-1:0]         dep_vec;
  logic                     err_r;
  logic                     drop;

  // Ready looks only at registered state; id 0 is always accepted when hardwired.
  assign score_ready_o = (cnt_r[score_id_i] != cnt_max) ||
                         ((hardwire_zero_p != 0) && (score_id_i == '0));
  assign drop          = score_v_i && !score_ready_o;

  // Next counter value per register: add the accepted score, subtract clears, saturate at 0.
  always_comb begin
    for (int r = 0; r < els_p; r++) begin
      inc[r] = score_v_i && score_ready_o && (score_id_i == id_width_p'(r)) &&
               !((hardwire_zero_p != 0) && (r == 0));
      dec[r] = '0;
      for (int k = 0; k < num_clear_p; k++) begin
        if (clear_v_i[k] && (clear_id_i[k] == id_width_p'(r)))
          dec[r] = dec[r] + dw'(1);
      end
      sum[r]   = aw'(cnt_r[r]) + aw'(inc[r]) - aw'(dec[r]);
      uflow[r] = sum[r][aw-1];
      cnt_n[r] = uflow[r] ? '0 : count_width_p'(sum[r]);
    end
  end

  // Counter and sticky error registers; reset wins over any concurrent score or clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < els_p; r++) cnt_r[r] <= '0;
      err_r <= 1'b0;
    end else begin
      for (int r = 0; r < els_p; r++) cnt_r[r] <= cnt_n[r];
      err_r <= err_r || drop || (|uflow);
    end
  end

  // Per-register busy vector seen by the dependency check.
  always_comb begin
    for (int r = 0; r < els_p; r++) begin
`ifdef VANILLA_LOAD_SB_CLEAR_BYPASS_EN
      // Scores are deliberately excluded: only the clears shorten the stall.
      dep_vec[r] = (aw'(cnt_r[r]) > aw'(dec[r]));
`else
      dep_vec[r] = (cnt_r[r] != '0);
`endif
    end
  end

  // Dependency lookups; hardwired x0 never reports a dependency.
  always_comb begin
    for (int k = 0; k < num_check_p; k++) begin
      dep_o[k] = dep_vec[check_id_i[k]] &&
                 !((hardwire_zero_p != 0) && (check_id_i[k] == '0));
    end
  end

  // Status views derived from registered counters only.
  always_comb begin
    for (int r = 0; r < els_p; r++) pending_o[r] = (cnt_r[r] != '0);
  end

  assign idle_o = ~|pending_o;
  assign err_o  = err_r;

endmodule

// File: tb/tb_vanilla_load_scoreboard.sv
// Directed bench for vanilla_load_scoreboard: a vector table for the main
// counting behaviour plus hand-written sequences for reset, underflow,
// bypass, the zero register and mid-operation reset.
module tb_vanilla_load_scoreboard;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             score_v_i;
  logic [4:0]       score_id_i;
  logic             score_ready_o, score_ready0;
  logic [1:0]       clear_v_i;
  logic [1:0][4:0]  clear_id_i;
  logic [2:0][4:0]  check_id_i;
  logic [2:0]       dep_o, dep0;
  logic [31:0]      pending_o, pending0;
  logic             idle_o, idle0;
  logic             err_o, err0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  vanilla_load_scoreboard dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .score_v_i(score_v_i), .score_id_i(score_id_i), .score_ready_o(score_ready_o),
    .clear_v_i(clear_v_i), .clear_id_i(clear_id_i), .check_id_i(check_id_i),
    .dep_o(dep_o), .pending_o(pending_o), .idle_o(idle_o), .err_o(err_o)
  );

  vanilla_load_scoreboard #(.hardwire_zero_p(0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i),
    .score_v_i(score_v_i), .score_id_i(score_id_i), .score_ready_o(score_ready0),
    .clear_v_i(clear_v_i), .clear_id_i(clear_id_i), .check_id_i(check_id_i),
    .dep_o(dep0), .pending_o(pending0), .idle_o(idle0), .err_o(err0)
  );

  typedef struct {
    logic        sv;
    logic [4:0]  sid;
    logic [1:0]  cv;
    logic [4:0]  c0, c1;
    logic [4:0]  k0, k1, k2;
    logic        rdy;
    logic [2:0]  dep;
    logic [31:0] pend;
    logic        idle;
    logic        err;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(input logic sv, input logic [4:0] sid, input logic [1:0] cv,
                              input logic [4:0] c0, input logic [4:0] c1,
                              input logic [4:0] k0, input logic [4:0] k1, input logic [4:0] k2,
                              input logic rdy, input logic [2:0] dep, input logic [31:0] pend,
                              input logic idle, input logic err);
    vec_t v;
    v.sv = sv; v.sid = sid; v.cv = cv; v.c0 = c0; v.c1 = c1;
    v.k0 = k0; v.k1 = k1; v.k2 = k2;
    v.rdy = rdy; v.dep = dep; v.pend = pend; v.idle = idle; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    score_v_i  = 1'b0;
    score_id_i = 5'd0;
    clear_v_i  = 2'b00;
    clear_id_i = '0;
    check_id_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    // pre-edge state | this cycle's stimulus
    vt[0]  = mk(0, 0, 2'b00, 0, 0, 5, 7, 0, 1, 3'b000, 32'h000, 1, 0);
    vt[1]  = mk(1, 5, 2'b00, 0, 0, 5, 7, 0, 1, 3'b000, 32'h000, 1, 0);
    vt[2]  = mk(1, 5, 2'b00, 0, 0, 5, 7, 0, 1, 3'b001, 32'h020, 0, 0);
    vt[3]  = mk(1, 5, 2'b00, 0, 0, 5, 7, 0, 1, 3'b001, 32'h020, 0, 0);
    vt[4]  = mk(1, 5, 2'b00, 0, 0, 5, 7, 0, 0, 3'b001, 32'h020, 0, 0);
    vt[5]  = mk(1, 7, 2'b00, 0, 0, 5, 7, 0, 1, 3'b001, 32'h020, 0, 1);
    vt[6]  = mk(0, 7, 2'b01, 5, 0, 7, 9, 0, 1, 3'b001, 32'h0A0, 0, 1);
    vt[7]  = mk(1, 7, 2'b01, 7, 0, 5, 9, 0, 1, 3'b001, 32'h0A0, 0, 1);
    vt[8]  = mk(0, 5, 2'b00, 0, 0, 7, 5, 0, 1, 3'b011, 32'h0A0, 0, 1);
    vt[9]  = mk(1, 9, 2'b00, 0, 0, 7, 5, 9, 1, 3'b011, 32'h0A0, 0, 1);
    vt[10] = mk(1, 9, 2'b00, 0, 0, 7, 5, 9, 1, 3'b111, 32'h2A0, 0, 1);
    vt[11] = mk(0, 9, 2'b11, 9, 9, 7, 5, 0, 1, 3'b011, 32'h2A0, 0, 1);
    vt[12] = mk(0, 5, 2'b00, 0, 0, 9, 5, 7, 1, 3'b110, 32'h0A0, 0, 1);
    vt[13] = mk(0, 5, 2'b11, 5, 5, 7, 0, 0, 1, 3'b001, 32'h0A0, 0, 1);
    vt[14] = mk(0, 5, 2'b10, 0, 7, 5, 0, 0, 1, 3'b000, 32'h080, 0, 1);
    vt[15] = mk(0, 5, 2'b00, 0, 0, 5, 7, 0, 1, 3'b000, 32'h000, 1, 1);

    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    #1;

    // reset state
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_dep", 32'(dep_o), 32'd0);
    for (int i = 0; i < 32; i++) begin
      score_id_i = 5'(i);
      #1;
      chk($sformatf("rst_ready_id%0d", i), 32'(score_ready_o), 32'd1);
    end
    score_id_i = 5'd0;

    // main table
    for (int i = 0; i < 16; i++) begin
      score_v_i     = vt[i].sv;
      score_id_i    = vt[i].sid;
      clear_v_i     = vt[i].cv;
      clear_id_i[0] = vt[i].c0;
      clear_id_i[1] = vt[i].c1;
      check_id_i[0] = vt[i].k0;
      check_id_i[1] = vt[i].k1;
      check_id_i[2] = vt[i].k2;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(score_ready_o), 32'(vt[i].rdy));
      chk($sformatf("v%0d_dep", i), 32'(dep_o), 32'(vt[i].dep));
      chk($sformatf("v%0d_pending", i), pending_o, vt[i].pend);
      chk($sformatf("v%0d_idle", i), 32'(idle_o), 32'(vt[i].idle));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vt[i].err));
      tick();
    end
    idle_inputs();

    // underflow: clear id 4 with nothing outstanding
    do_reset();
    chk("uf_err_before", 32'(err_o), 32'd0);
    clear_v_i = 2'b01; clear_id_i[0] = 5'd4;
    tick();
    idle_inputs();
    #1;
    chk("uf_err", 32'(err_o), 32'd1);
    chk("uf_pending", pending_o, 32'h0);
    chk("uf_idle", 32'(idle_o), 32'd1);

    // bypass: last response for id 3 retires while id 3 is being checked
    do_reset();
    score_v_i = 1'b1; score_id_i = 5'd3;
    tick();
    score_v_i = 1'b0;
    check_id_i[0] = 5'd3;
    clear_v_i = 2'b01; clear_id_i[0] = 5'd3;
    #1;
`ifdef VANILLA_LOAD_SB_CLEAR_BYPASS_EN
    chk("byp_same_cycle", 32'(dep_o[0]), 32'd0);
`else
    chk("byp_same_cycle", 32'(dep_o[0]), 32'd1);
`endif
    chk("byp_pending_same", pending_o, 32'h8);
    tick();
    clear_v_i = 2'b00;
    #1;
    chk("byp_next_cycle", 32'(dep_o[0]), 32'd0);
    chk("byp_err", 32'(err_o), 32'd0);

    // zero register: hardwired instance ignores x0, the other tracks it
    do_reset();
    score_v_i = 1'b1; score_id_i = 5'd0;
    #1;
    chk("zero_ready", 32'(score_ready_o), 32'd1);
    tick();
    score_v_i = 1'b0;
    #1;
    chk("zero_idle", 32'(idle_o), 32'd1);
    chk("zero_err", 32'(err_o), 32'd0);
    chk("zero_dep", 32'(dep_o), 32'd0);
    chk("zero_pending", pending_o, 32'h0);
    chk("nz_pending", pending0, 32'h1);
    chk("nz_idle", 32'(idle0), 32'd0);
    chk("nz_dep", 32'(dep0), 32'b111);
    chk("nz_err", 32'(err0), 32'd0);

    // mid-operation reset overrides a concurrent score
    do_reset();
    score_v_i = 1'b1; score_id_i = 5'd2;
    tick();
    chk("mr_pending_before", pending_o, 32'h4);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    score_v_i = 1'b0;
    #1;
    chk("mr_pending", pending_o, 32'h0);
    chk("mr_err", 32'(err_o), 32'd0);
    chk("mr_idle", 32'(idle_o), 32'd1);
    chk("mr_ready", 32'(score_ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
